// File: rtl/pool_window_sequencer_if.sv
// pool_window_sequencer_if
//   Groups the three buses that the window sequencer drives or consumes:
//   - input feature-map RAM read port (rd_en / rd_addr / rd_data)
//   - pooling-unit start/finish handshake (pool_start / pool_win / pool_finish / pool_pixel)
//   - output RAM write port (wr_en / wr_addr / wr_data)
//
//   Handshake semantics (pooling unit):
//     The sequencer raises pool_start with pool_win stable and holds both
//     until it has seen pool_finish=1. pool_pixel is valid while pool_finish=1.
//     The sequencer then drops pool_start and the pooling unit must drop
//     pool_finish before the next pool_start is raised. The read port has a
//     fixed 1-cycle latency: rd_data is valid the cycle after rd_en=1.
//
//   Modports: master = sequencer side, slave = RAM / pooling-unit side.
interface pool_window_sequencer_if #(
  parameter int DW  = 16,
  parameter int WIN = 5,
  parameter int AW  = 10
);
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic [DW-1:0]         rd_data;
  logic                  pool_start;
  logic [WIN*WIN*DW-1:0] pool_win;
  logic                  pool_finish;
  logic [DW-1:0]         pool_pixel;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DW-1:0]         wr_data;

  modport master (
    output rd_en, rd_addr, pool_start, pool_win, wr_en, wr_addr, wr_data,
    input  rd_data, pool_finish, pool_pixel
  );

  modport slave (
    input  rd_en, rd_addr, pool_start, pool_win, wr_en, wr_addr, wr_data,
    output rd_data, pool_finish, pool_pixel
  );
endinterface

// File: rtl/pool_window_sequencer.sv
// pool_window_sequencer
//   Walks a feature map held in a 1-cycle-latency RAM, assembles each
//   WIN x WIN window (pixels outside the image read as 0), hands it to the
//   pooling unit via the start/finish handshake and writes the pooled result
//   to the output RAM at orow*OUT_W+ocol.
//
//   Ports:
//     clk, rst_n  clock (rising edge), asynchronous active-low reset
//     go          start a full-image pass (accepted in IDLE only)
//     busy        high from go acceptance until the pass completes
//     done        1-cycle pulse after the last result has been written
//     err         sticky watchdog error (constant 0 unless POOL_TIMEOUT_EN)
//     state_dbg   current FSM state encoding
//     bus         pool_window_sequencer_if.master (RAM read, pool handshake, RAM write)
//
//   Optional feature macro: POOL_TIMEOUT_EN -- adds a TMO-cycle watchdog on
//   the ISSUE and RELEASE waits; on expiry the pass is abandoned and err set.
module pool_window_sequencer #(
  parameter int DW     = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int WIN    = 5,
  parameter int STRIDE = 2,
  parameter int AW     = 10,
  parameter int TMO    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [2:0]            state_dbg,
  pool_window_sequencer_if.master bus
);
  localparam int OUT_W = (IMG_W - 2) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - 2) / STRIDE + 1;
  localparam int NPIX  = WIN * WIN;
  localparam int CW    = $clog2(NPIX + 1);
  localparam int PW    = 16;  // pixel/window coordinate width

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    ISSUE   = 3'd2,
    CAPTURE = 3'd3,
    RELEASE = 3'd4,
    FINISH  = 3'd5
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   fcnt;          // fetch step, 0..NPIX (NPIX = drain cycle)
  logic [PW-1:0]   wrow, wcol;    // pixel position inside the window
  logic [PW-1:0]   orow, ocol;    // output (window) coordinates
  logic            st_vld, st_inb;
  logic [CW-1:0]   st_idx;        // window slot that the returning read fills
  logic [DW-1:0]   win_q [NPIX];
  logic [DW-1:0]   pix_q;
  logic [PW-1:0]   prow, pcol;
  logic            inb, fetching, last_win, rd_go, tmo_hit;

  always_comb begin
    prow     = orow * PW'(STRIDE) + wrow;
    pcol     = ocol * PW'(STRIDE) + wcol;
    inb      = (prow < PW'(IMG_H)) && (pcol < PW'(IMG_W));
    fetching = (state == FETCH) && (fcnt < CW'(NPIX));
    rd_go    = fetching && inb;
    last_win = (orow == PW'(OUT_H - 1)) && (ocol == PW'(OUT_W - 1));
  end

`ifdef POOL_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  // Counts cycles spent waiting in the current ISSUE or RELEASE visit.
  assign tmo_hit = (tmo_cnt == TW'(TMO - 1)) &&
                   (((state == ISSUE) && !bus.pool_finish) ||
                    ((state == RELEASE) && bus.pool_finish));
  assign err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_n != state)
        tmo_cnt <= '0;
      else if ((state == ISSUE) || (state == RELEASE))
        tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit)
        err_q <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (go && !bus.pool_finish) state_n = FETCH;
      FETCH:   if (fcnt == CW'(NPIX)) state_n = ISSUE;
      ISSUE:   if (bus.pool_finish) state_n = CAPTURE;
               else if (tmo_hit)    state_n = IDLE;
      CAPTURE: state_n = RELEASE;
      RELEASE: if (!bus.pool_finish) state_n = last_win ? FINISH : FETCH;
               else if (tmo_hit)     state_n = IDLE;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state == FETCH) || (state == ISSUE) ||
                     (state == CAPTURE) || (state == RELEASE);
    done           = (state == FINISH);
    state_dbg      = state;
    bus.pool_start = (state == ISSUE) || (state == CAPTURE);
    bus.rd_en      = rd_go;
    bus.rd_addr    = '0;
    if (rd_go)
      bus.rd_addr = AW'(prow * PW'(IMG_W) + pcol);
    bus.wr_en   = (state == CAPTURE);
    bus.wr_addr = '0;
    bus.wr_data = '0;
    if (state == CAPTURE) begin
      bus.wr_addr = AW'(orow * PW'(OUT_W) + ocol);
      bus.wr_data = pix_q;
    end
    for (int i = 0; i < NPIX; i++)
      bus.pool_win[i*DW +: DW] = win_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      fcnt   <= '0;
      wrow   <= '0;
      wcol   <= '0;
      orow   <= '0;
      ocol   <= '0;
      st_vld <= 1'b0;
      st_inb <= 1'b0;
      st_idx <= '0;
      pix_q  <= '0;
      for (int i = 0; i < NPIX; i++)
        win_q[i] <= '0;
    end else begin
      state <= state_n;

      // One-stage pipeline matching the RAM latency: the slot issued this
      // cycle is filled next cycle, with 0 for out-of-image pixels.
      st_vld <= fetching;
      st_inb <= inb;
      st_idx <= fcnt;
      if (st_vld)
        win_q[st_idx] <= st_inb ? bus.rd_data : '0;

      if (fetching) begin
        fcnt <= fcnt + 1'b1;
        if (wcol == PW'(WIN - 1)) begin
          wcol <= '0;
          wrow <= wrow + 1'b1;
        end else begin
          wcol <= wcol + 1'b1;
        end
      end else if (state != FETCH) begin
        fcnt <= '0;
        wrow <= '0;
        wcol <= '0;
      end

      if ((state == ISSUE) && bus.pool_finish)
        pix_q <= bus.pool_pixel;

      if ((state == IDLE) && (state_n == FETCH)) begin
        orow <= '0;
        ocol <= '0;
      end else if ((state == RELEASE) && (state_n == FETCH)) begin
        if (ocol == PW'(OUT_W - 1)) begin
          ocol <= '0;
          orow <= orow + 1'b1;
        end else begin
          ocol <= ocol + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pool_window_sequencer.sv
// tb_pool_window_sequencer
//   4x4 image holding 0..15, WIN=3, STRIDE=2 -> 2x2 outputs. The pooling
//   model averages the top-left 2x2 of each window, so results are 2,4,10,12.
module tb_pool_window_sequencer;
  localparam int DW = 16, IMG_W = 4, IMG_H = 4, WIN = 3, STRIDE = 2, AW = 6, TMO = 8;

  logic       clk;
  logic       rst_n;
  logic       go;
  logic       busy, done, err;
  logic [2:0] state_dbg;

  pool_window_sequencer_if #(.DW(DW), .WIN(WIN), .AW(AW)) bus ();

  pool_window_sequencer #(
    .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN),
    .STRIDE(STRIDE), .AW(AW), .TMO(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .busy(busy), .done(done),
    .err(err), .state_dbg(state_dbg), .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int wr_cnt, done_cnt, bad_rd, rel_viol, rel_cycles, stab_viol, win_idx, hold_extra;
  logic [21:0]  exp_q[$];
  logic [255:0] win_snap [4];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] win_exp(input int orow, input int ocol);
    logic [255:0] v;
    v = '0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++) begin
        int pr, pc;
        pr = orow * STRIDE + r;
        pc = ocol * STRIDE + c;
        if (pr < IMG_H && pc < IMG_W)
          v[(r*WIN+c)*DW +: DW] = 16'(pr * IMG_W + pc);
      end
    return v;
  endfunction

  // input RAM model: 1-cycle latency, image pixel value = its address
  logic        ram_pend;
  logic [15:0] ram_val;
  initial begin
    bus.rd_data = 16'hDEAD;
    ram_pend    = 1'b0;
    ram_val     = '0;
    forever begin
      @(negedge clk);
      bus.rd_data = ram_pend ? ram_val : 16'hDEAD;
      ram_pend    = rst_n && bus.rd_en;
      ram_val     = (bus.rd_addr < 16) ? 16'(bus.rd_addr) : 16'hBAD0;
    end
  end

  // pooling unit model: finish 3 cycles after start, hold finish hold_extra
  // cycles after start drops
  initial begin
    int pm, dly, hcnt, sum;
    logic [WIN*WIN*DW-1:0] snap;
    bus.pool_finish = 1'b0;
    bus.pool_pixel  = '0;
    pm = 0; dly = 0; hcnt = 0; snap = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.pool_finish = 1'b0;
        pm = 0;
      end else begin
        case (pm)
          0: if (bus.pool_start) begin
               snap = bus.pool_win;
               if (win_idx < 4) win_snap[win_idx] = 256'(snap);
               win_idx++;
               dly = 0;
               pm  = 1;
             end
          1: begin
               if (bus.pool_win !== snap) stab_viol++;
               dly++;
               if (dly == 3) begin
                 sum = int'(snap[0 +: DW]) + int'(snap[DW +: DW]) +
                       int'(snap[WIN*DW +: DW]) + int'(snap[(WIN+1)*DW +: DW]);
                 bus.pool_pixel  = 16'(sum / 4);
                 bus.pool_finish = 1'b1;
                 pm = 2;
               end
             end
          2: begin
               if (bus.pool_start) begin
                 if (bus.pool_win !== snap) stab_viol++;
               end else if (hold_extra == 0) begin
                 bus.pool_finish = 1'b0;
                 pm = 0;
               end else begin
                 hcnt = 1;
                 pm = 3;
               end
             end
          default: begin
               if (hcnt >= hold_extra) begin
                 bus.pool_finish = 1'b0;
                 pm = 0;
               end else begin
                 hcnt++;
               end
             end
        endcase
      end
    end
  end

  // scoreboard / monitor, sampled just after the active edge
  initial begin
    logic [21:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.rd_en && bus.rd_addr >= 16) bad_rd++;
      if (busy && bus.pool_finish && !bus.pool_start) begin
        rel_cycles++;
        if (bus.rd_en) rel_viol++;
      end
      if (done) done_cnt++;
      if (bus.wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 256'(bus.wr_addr), 256'(6'h3f));
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 256'(bus.wr_addr), 256'(e[21:16]));
          check("wr_data", 256'(bus.wr_data), 256'(e[15:0]));
        end
      end
    end
  end

  // driver tasks
  task automatic start_pass();
    exp_q.delete();
    exp_q.push_back({6'd0, 16'd2});
    exp_q.push_back({6'd1, 16'd4});
    exp_q.push_back({6'd2, 16'd10});
    exp_q.push_back({6'd3, 16'd12});
    wr_cnt = 0; done_cnt = 0; win_idx = 0; bad_rd = 0; stab_viol = 0;
    rel_cycles = 0; rel_viol = 0;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("go_busy", 256'(busy), 256'(1));
    check("go_rd_en", 256'(bus.rd_en), 256'(1));
    check("go_rd_addr", 256'(bus.rd_addr), 256'(0));
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 256'(done_cnt != 0), 256'(1));
  endtask

  task automatic check_pass(input string name);
    check({name, "_wr_cnt"}, 256'(wr_cnt), 256'(4));
    check({name, "_done_cnt"}, 256'(done_cnt), 256'(1));
    check({name, "_exp_left"}, 256'(exp_q.size()), 256'(0));
    check({name, "_busy_end"}, 256'(busy), 256'(0));
    check({name, "_bad_rd"}, 256'(bad_rd), 256'(0));
    check({name, "_win_stable"}, 256'(stab_viol), 256'(0));
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, 256'(busy), 256'(0));
    check({name, "_done"}, 256'(done), 256'(0));
    check({name, "_err"}, 256'(err), 256'(0));
    check({name, "_state"}, 256'(state_dbg), 256'(0));
    check({name, "_rd_en"}, 256'(bus.rd_en), 256'(0));
    check({name, "_rd_addr"}, 256'(bus.rd_addr), 256'(0));
    check({name, "_start"}, 256'(bus.pool_start), 256'(0));
    check({name, "_win"}, 256'(bus.pool_win), 256'(0));
    check({name, "_wr_en"}, 256'(bus.wr_en), 256'(0));
    check({name, "_wr_addr"}, 256'(bus.wr_addr), 256'(0));
    check({name, "_wr_data"}, 256'(bus.wr_data), 256'(0));
  endtask

  // directed sequence
  initial begin
    int n;
    rst_n = 1'b0;
    go = 1'b0;
    hold_extra = 0;
    wr_cnt = 0; done_cnt = 0; bad_rd = 0; rel_viol = 0; rel_cycles = 0;
    stab_viol = 0; win_idx = 0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // full pass, with go re-pulsed mid-pass
    start_pass();
    repeat (30) @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_done(600);
    repeat (20) @(negedge clk);
    check_pass("pass1");
    check("win0", win_snap[0], win_exp(0, 0));
    check("win1", win_snap[1], win_exp(0, 1));
    check("win2", win_snap[2], win_exp(1, 0));
    check("win3_padded", win_snap[3], win_exp(1, 1));
    check("win_last_held", 256'(bus.pool_win), win_exp(1, 1));

    // pooling unit holds finish 5 cycles after start drops
    hold_extra = 5;
    start_pass();
    wait_done(800);
    repeat (10) @(negedge clk);
    check_pass("hold");
    check("hold_rel_rd_en", 256'(rel_viol), 256'(0));
    check("hold_rel_waited", 256'(rel_cycles >= 20), 256'(1));
    hold_extra = 0;

    // asynchronous reset during the fetch of window 2
    start_pass();
    n = 0;
    while (wr_cnt == 0 && n < 200) begin @(negedge clk); n++; end
    check("rst_first_write", 256'(wr_cnt), 256'(1));
    n = 0;
    while (!bus.rd_en && n < 50) begin @(negedge clk); n++; end
    check("rst_in_fetch", 256'(state_dbg), 256'(1));
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    start_pass();
    wait_done(600);
    repeat (10) @(negedge clk);
    check_pass("after_rst");
    check("after_rst_err", 256'(err), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
